// File: rtl/adc_seq_pkg.sv
// Shared types and helpers for the ADC conversion sequencer.
package adc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CNV       = 3'd1,
    WAIT_BUSY = 3'd2,
    REQ       = 3'd3,
    READ      = 3'd4
  } state_e;

  // Cycles busy_s is ignored after cnv falls; covers the synchronizer delay
  localparam int GUARD = 3;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v == max) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer, async active-high reset.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/adc_conversion_sequencer.sv
// One ADC conversion per trigger: cnv pulse, wait for busy low (with timeout),
// then a valid/ready readout request to the SPI engine. Tracks overruns/timeouts.
module adc_conversion_sequencer
  import adc_seq_pkg::*;
#(
  parameter int CNV_W     = 8,
  parameter int TIMEOUT_W = 16,
  parameter int CNT_W     = 16
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 enable,
  input  logic                 trigger,
  input  logic [CNV_W-1:0]     cnv_width,
  input  logic [TIMEOUT_W-1:0] busy_timeout,
  input  logic                 clear_counts,
  input  logic                 busy,
  output logic                 cnv,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  input  logic                 rd_done,
  output logic                 active,
  output logic [CNT_W-1:0]     overrun_count,
  output logic [CNT_W-1:0]     timeout_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e               state_q, state_d;
  logic                 busy_s;
  logic                 cnv_q;
  logic [CNV_W-1:0]     wcnt_q;
  logic [1:0]           guard_q;
  logic [TIMEOUT_W-1:0] tcnt_q, tmo_lat_q, tcnt_inc;
  logic [CNT_W-1:0]     ovr_q, tmo_q;
  logic                 tmo_hit;

  sync_2ff #(.W(1)) u_busy_sync (
    .clk (aclk),
    .rst (areset),
    .d   (busy),
    .q   (busy_s)
  );

  assign tcnt_inc = tcnt_q + TIMEOUT_W'(1);

  always_comb begin
    state_d = state_q;
    tmo_hit = 1'b0;
    case (state_q)
      IDLE:      if (trigger && enable) state_d = CNV;
      CNV:       if (wcnt_q <= CNV_W'(1)) state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        // Busy low takes priority over a timeout landing on the same cycle
        if (guard_q == 2'd0 && !busy_s) begin
          state_d = REQ;
        end else if (tmo_lat_q != '0 && tcnt_inc == tmo_lat_q) begin
          state_d = IDLE;
          tmo_hit = 1'b1;
        end
      end
      REQ:       if (rd_ready) state_d = READ;
      READ:      if (rd_done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= IDLE;
      cnv_q     <= 1'b0;
      wcnt_q    <= '0;
      guard_q   <= '0;
      tcnt_q    <= '0;
      tmo_lat_q <= '0;
    end else begin
      state_q <= state_d;
      cnv_q   <= (state_d == CNV);
      if (state_q == IDLE && state_d == CNV)
        wcnt_q <= (cnv_width == '0) ? CNV_W'(1) : cnv_width;
      else if (state_q == CNV)
        wcnt_q <= wcnt_q - CNV_W'(1);
      if (state_q == CNV && state_d == WAIT_BUSY) begin
        guard_q   <= 2'(GUARD);
        tcnt_q    <= '0;
        tmo_lat_q <= busy_timeout;
      end else if (state_q == WAIT_BUSY) begin
        if (guard_q != 2'd0) guard_q <= guard_q - 2'd1;
        tcnt_q <= tcnt_inc;
      end
    end
  end

  // Clear wins over any increment in the same cycle
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ovr_q <= '0;
      tmo_q <= '0;
    end else if (clear_counts) begin
      ovr_q <= '0;
      tmo_q <= '0;
    end else begin
      if (trigger && state_q != IDLE) ovr_q <= CNT_W'(sat_inc(32'(ovr_q), 32'(CNT_MAX)));
      if (tmo_hit)                    tmo_q <= CNT_W'(sat_inc(32'(tmo_q), 32'(CNT_MAX)));
    end
  end

  assign cnv           = cnv_q;
  assign rd_valid      = (state_q == REQ);
  assign active        = (state_q != IDLE);
  assign overrun_count = ovr_q;
  assign timeout_count = tmo_q;

endmodule

// File: tb/tb_adc_conversion_sequencer.sv
// Bench for adc_conversion_sequencer: each sequence's timeline is predicted
// arithmetically from its parameters and compared cycle by cycle.
module tb_adc_conversion_sequencer;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        enable = 1'b0, trigger = 1'b0, clear_counts = 1'b0, busy = 1'b0;
  logic [7:0]  cnv_width = '0;
  logic [15:0] busy_timeout = '0;
  logic        cnv, rd_valid, rd_ready = 1'b0, rd_done = 1'b0, active;
  logic [15:0] overrun_count, timeout_count;

  int ncmp = 0, nerr = 0;
  int ov_m = 0, tc_m = 0;

  always #5 aclk = ~aclk;

  adc_conversion_sequencer dut (
    .aclk(aclk), .areset(areset), .enable(enable), .trigger(trigger),
    .cnv_width(cnv_width), .busy_timeout(busy_timeout), .clear_counts(clear_counts),
    .busy(busy), .cnv(cnv), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_done(rd_done),
    .active(active), .overrun_count(overrun_count), .timeout_count(timeout_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // Observation index i is the negedge after the i-th posedge following the
  // trigger. cnv spans i<w'; busy_s decision edge is max(B+3, w'+4); timeout
  // edge is w'+to; rd_valid spans D..D+R; active ends after rd_done edge.
  task automatic run_seq(input int w, input int b, input int r, input int q, input int to,
                         input bit trig_all, input bit rand_trig, input int clr_at);
    int wp, d, a, e;
    bit tmo, trg;
    wp  = (w == 0) ? 1 : w;
    d   = (b + 3 > wp + 4) ? b + 3 : wp + 4;
    tmo = (to != 0) && (wp + to < d);
    a   = d + r + 1;
    e   = tmo ? wp + to : a + q + 1;
    cnv_width = 8'(w); busy_timeout = 16'(to); enable = 1'b1; trigger = 1'b1;
    rd_ready = (r == 0); busy = 1'b0; rd_done = 1'b0; clear_counts = 1'b0;
    for (int i = 0; i <= e + 1; i++) begin
      @(negedge aclk);
      chk("cnv", cnv, 32'(i < wp));
      chk("rd_valid", rd_valid, 32'(!tmo && i >= d && i <= d + r));
      chk("active", active, 32'(i < e));
      chk("overrun_count", overrun_count, 32'(ov_m));
      chk("timeout_count", timeout_count, 32'(tc_m));
      trg = trig_all ? (i < e) : (rand_trig && i < e && $urandom_range(0, 3) == 0);
      if (i == clr_at) trg = (i < e);
      trigger      = trg;
      clear_counts = (i == clr_at);
      busy         = (i < b);
      rd_ready     = (r == 0) || (i >= d + r);
      rd_done      = (!tmo && i == a + q) || (i == 0);
      enable       = (i + 1 >= e) ? 1'b1 : 1'($urandom_range(0, 1));
      cnv_width    = 8'($urandom_range(0, 255));
      if (i >= wp) busy_timeout = 16'($urandom_range(1, 3));
      if (clear_counts) begin
        ov_m = 0; tc_m = 0;
      end else begin
        if (trg) ov_m = sat(ov_m);
        if (tmo && i == e - 1) tc_m = sat(tc_m);
      end
    end
    trigger = 1'b0; clear_counts = 1'b0; rd_done = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge aclk);
    chk("rst_cnv", cnv, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_active", active, 0);
    chk("rst_overrun", overrun_count, 0);
    chk("rst_timeout", timeout_count, 0);
    areset = 1'b0;
    @(negedge aclk);

    run_seq(5, 30, 0, 5, 0, 1'b0, 1'b0, -1);          // basic conversion
    run_seq(4, 200, 0, 0, 20, 1'b0, 1'b0, -1);        // busy timeout
    run_seq(3, 10, 2, 3, 0, 1'b0, 1'b1, -1);          // overruns

    enable = 1'b0; trigger = 1'b1;                    // disabled trigger in IDLE
    @(negedge aclk);
    trigger = 1'b0;
    repeat (4) begin
      @(negedge aclk);
      chk("dis_cnv", cnv, 0);
      chk("dis_active", active, 0);
      chk("dis_overrun", overrun_count, 32'(ov_m));
    end

    run_seq(2, 8, 7, 2, 0, 1'b0, 1'b0, -1);           // backpressure
    run_seq(0, 6, 1, 1, 0, 1'b1, 1'b0, 3);            // width 0, clear vs overrun
    run_seq(2, 10, 0, 0, 2, 1'b0, 1'b0, -1);          // timeout inside guard
    for (int k = 0; k < 20; k++)
      run_seq($urandom_range(0, 8), $urandom_range(1, 40), $urandom_range(0, 5),
              $urandom_range(0, 4), ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 50),
              1'b0, 1'b1, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 10) : -1);

    // Reset while a request is pending
    enable = 1'b1; cnv_width = 8'd2; busy_timeout = '0; rd_ready = 1'b0; busy = 1'b0;
    trigger = 1'b1;
    @(negedge aclk);
    trigger = 1'b0;
    n = 0;
    while (!rd_valid && n < 60) begin
      @(negedge aclk);
      n++;
    end
    chk("rst_reach_req", 32'(n < 60), 1);
    #2 areset = 1'b1;
    #1;
    chk("arst_rd_valid", rd_valid, 0);
    chk("arst_cnv", cnv, 0);
    chk("arst_active", active, 0);
    chk("arst_overrun", overrun_count, 0);
    @(negedge aclk);
    areset = 1'b0; ov_m = 0; tc_m = 0;
    @(negedge aclk);
    chk("post_rst_rd_valid", rd_valid, 0);
    run_seq(3, 12, 1, 2, 0, 1'b0, 1'b1, -1);

    // Saturation: trigger every cycle through a very long busy phase
    run_seq(1, 65545, 0, 0, 0, 1'b1, 1'b0, -1);
    chk("sat_overrun", overrun_count, 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
